// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle divider.
// Imported by div_unit and by any EX-stage logic that drives it.
package div_unit_pkg;

    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 64;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [5:0] DIV_ITERS = 6'd32;

endpackage

// File: rtl/div_unit.sv
// Restoring 32-bit divider, one quotient bit per cycle, for DIV/DIVU.
// Returns {remainder, quotient}; annul aborts, start held until ready.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        signed_div_i,
    input  logic [REG_BUS_W-1:0]        opdata1_i,
    input  logic [REG_BUS_W-1:0]        opdata2_i,
    input  logic                        start_i,
    input  logic                        annul_i,
    output logic [DOUBLE_REG_BUS_W-1:0] result_o,
    output logic                        ready_o
);

    div_state_e      state;
    logic [64:0]     dividend;
    logic [31:0]     divisor;
    logic [5:0]      cnt;
    logic            dvd_neg;
    logic            quo_neg;

    logic [32:0]     tmp;
    logic [31:0]     op1_abs;
    logic [31:0]     op2_abs;
    logic [31:0]     quo;
    logic [31:0]     rem;
    logic            op1_neg;
    logic            op2_neg;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[31];
        op2_neg = signed_div_i & opdata2_i[31];
        op1_abs = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_abs = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
        tmp     = {1'b0, dividend[63:32]} - {1'b0, divisor};
        // Signs are restored on the fix-up cycle from the latched flags.
        quo     = quo_neg ? (~dividend[31:0] + 32'd1) : dividend[31:0];
        rem     = dvd_neg ? (~dividend[64:33] + 32'd1) : dividend[64:33];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            dvd_neg  <= 1'b0;
            quo_neg  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state    <= DIV_ON;
                            cnt      <= 6'd0;
                            dividend <= {32'd0, op1_abs, 1'b0};
                            divisor  <= op2_abs;
                            dvd_neg  <= op1_neg;
                            quo_neg  <= op1_neg ^ op2_neg;
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                        cnt   <= 6'd0;
                    end else if (cnt != DIV_ITERS) begin
                        if (tmp[32]) begin
                            dividend <= {dividend[63:0], 1'b0};
                        end else begin
                            dividend <= {tmp[31:0], dividend[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem, quo};
                        ready_o  <= DIV_RESULT_READY;
                        state    <= DIV_END;
                        cnt      <= 6'd0;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a result scoreboard.
// Expected {rem, quo} pairs are queued at start and checked at ready.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        sdiv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(sdiv),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(bit s, logic [31:0] a,
                                          logic [31:0] b);
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'h0, 32'h8000_0000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    task automatic go(bit s, logic [31:0] a, logic [31:0] b,
                      logic [63:0] exp);
        sdiv  = s;
        op1   = a;
        op2   = b;
        start = 1'b1;
        sb.push_back(exp);
    endtask

    task automatic wait_ready(string tag, int exp_lat);
        int lat;
        logic [63:0] exp;
        lat = 0;
        while (!ready && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        exp = sb.pop_front();
        chk({tag, "_res"}, result, exp);
    endtask

    task automatic release_chk(string tag);
        start = 1'b0;
        chk({tag, "_hold"}, 64'(ready), 64'd1);
        tick();
        chk({tag, "_rdy_off"}, 64'(ready), 64'd0);
        chk({tag, "_res_off"}, result, 64'd0);
    endtask

    initial begin
        int seen;
        bit s;
        logic [31:0] a;
        logic [31:0] b;

        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sdiv  = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (2) tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        tick();

        go(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_ready("u100_7", 34);
        release_chk("u100_7");

        go(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_ready("s-7_2", 34);
        release_chk("s-7_2");

        go(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});
        wait_ready("uffff_1", 34);
        release_chk("uffff_1");

        go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        wait_ready("s_ovf", 34);
        release_chk("s_ovf");

        go(1'b0, 32'h1234_5678, 32'd0, 64'd0);
        wait_ready("byzero", 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("byzero_hold_rdy", 64'(ready), 64'd1);
            chk("byzero_hold_res", result, 64'd0);
        end
        release_chk("byzero");

        // Annul at the tenth ON cycle; result must never appear.
        sdiv  = 1'b0;
        op1   = 32'd100;
        op2   = 32'd7;
        start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) seen++;
            tick();
        end
        chk("annul_no_ready", 64'(seen), 64'd0);

        go(1'b0, 32'd20, 32'd3, {32'd2, 32'd6});
        wait_ready("u20_3", 34);
        release_chk("u20_3");

        // Reset in the middle of a division.
        sdiv  = 1'b0;
        op1   = 32'd100;
        op2   = 32'd7;
        start = 1'b1;
        repeat (20) tick();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_result", result, 64'd0);
        rst = 1'b0;

        go(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100});
        wait_ready("post_rst", 34);
        release_chk("post_rst");

        // Operands change after acceptance; result must follow the originals.
        go(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        repeat (3) tick();
        op1  = 32'd5;
        op2  = 32'd0;
        sdiv = 1'b0;
        wait_ready("opchg", 31);
        release_chk("opchg");

        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            go(s, a, b, model(s, a, b));
            wait_ready("rand", 34);
            release_chk("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
